// File: rtl/regfile_hilo_sb_pkg.sv
// Shared constants and helpers for the decode-stage register file and its
// HI/LO mul/div scoreboard.
package regfile_pkg;

  localparam int ZERO_REG = 0;
  localparam logic MF_LO = 1'b0;
  localparam logic MF_HI = 1'b1;
  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_hilo_sb_hilo_scoreboard.sv
// HI/LO registers plus the outstanding mul/div counter that decides when an
// MFHI/MFLO read may proceed.
module hilo_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MD_DEPTH = 2,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              md_start,
  input  logic              md_valid,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hilo_wdata,
  input  logic              mf_sel,
  output logic [DATA_W-1:0] mf_data,
  output logic              mf_stall,
  output logic              md_full,
  output logic [1:0]        err
);

  localparam int CW = clog2(MD_DEPTH + 1);

  logic [CW-1:0]     pend;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              full;
  logic              empty;
  logic              start_ok;
  logic              valid_ok;
  logic [DATA_W-1:0] hi_fwd;
  logic [DATA_W-1:0] lo_fwd;

  assign full     = (pend == CW'(MD_DEPTH));
  assign empty    = (pend == '0);
  // A start at full is only accepted when a result drains in the same cycle.
  assign start_ok = md_start && (!full || md_valid);
  assign valid_ok = md_valid && !empty;
  assign md_full  = full;

  // MT writes are younger than any in-flight result, so they take priority.
  assign hi_fwd = hi_we ? hilo_wdata : (valid_ok ? md_hi : hi_q);
  assign lo_fwd = lo_we ? hilo_wdata : (valid_ok ? md_lo : lo_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      hi_q <= '0;
      lo_q <= '0;
      err  <= '0;
    end else begin
      pend <= pend + CW'(start_ok) - CW'(valid_ok);
      hi_q <= hi_fwd;
      lo_q <= lo_fwd;
      if (md_start && full && !md_valid) err[ERR_OVF] <= 1'b1;
      if (md_valid && empty)             err[ERR_UNF] <= 1'b1;
    end
  end

  always_comb begin
    mf_stall = !empty;
    if ((BYPASS != 0) && (pend == CW'(1)) && md_valid && !md_start) mf_stall = 1'b0;
  end

  always_comb begin
    mf_data = (mf_sel == MF_HI) ? hi_q : lo_q;
    if (BYPASS != 0) mf_data = (mf_sel == MF_HI) ? hi_fwd : lo_fwd;
  end

endmodule

// File: rtl/regfile_hilo_sb.sv
// Decode-stage GPR file with same-cycle write forwarding, wrapped around the
// HI/LO scoreboard for the multi-cycle mul/div unit.
module regfile_hilo_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int MD_DEPTH = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(NREG)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  md_start,
  input  logic                  md_valid,
  input  logic [DATA_W-1:0]     md_hi,
  input  logic [DATA_W-1:0]     md_lo,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_W-1:0]     hilo_wdata,
  input  logic                  mf_sel,
  output logic [DATA_W-1:0]     mf_data,
  output logic                  mf_stall,
  output logic                  md_full,
  output logic [1:0]            err
);

  logic [DATA_W-1:0] regs [NREG];

  // r0 is never written, so it keeps its reset value of zero forever.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != AW'(ZERO_REG))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = rd_addr[k*AW +: AW];
    assign hit = (BYPASS != 0) && wr_en && (wr_addr == ra) && (ra != AW'(ZERO_REG));
    assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs[ra];
  end

  hilo_scoreboard #(
    .DATA_W  (DATA_W),
    .MD_DEPTH(MD_DEPTH),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .md_start  (md_start),
    .md_valid  (md_valid),
    .md_hi     (md_hi),
    .md_lo     (md_lo),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hilo_wdata(hilo_wdata),
    .mf_sel    (mf_sel),
    .mf_data   (mf_data),
    .mf_stall  (mf_stall),
    .md_full   (md_full),
    .err       (err)
  );

endmodule
